m_dmem_responder: RTL and testbench

//  Responder side of the processor data-memory bus (WE/address/wdata/rdata).

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/m_sync_fifo.sv | 62 ++++++
 rtl/m_dmem_responder.sv | 140 ++++++++++++++
 tb/tb_m_dmem_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared constants for the data-memory responder: the memory map and the bit
// layout of the console STATUS register.
//   RAM_BASE      start of word RAM
//   TX_DATA_ADDR  console transmit byte (write pushes, read returns 0)
//   STATUS_ADDR   console status (read) / overflow clear (write)
//   CYCLE_ADDR    free-running cycle counter (when DMEM_CYCLE_COUNTER_EN)
// -----------------------------------------------------------------------------
package dmem_pkg;

  localparam logic [31:0] RAM_BASE     = 32'h0000_0000;
  localparam logic [31:0] TX_DATA_ADDR = 32'hFFFF_0000;
  localparam logic [31:0] STATUS_ADDR  = 32'hFFFF_0004;
  localparam logic [31:0] CYCLE_ADDR   = 32'hFFFF_0008;

  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_FULL_BIT  = 2;
  localparam int STAT_OVF_BIT   = 3;
  localparam int STAT_COUNT_LSB = 8;

  // Word-granular address compare; the byte-offset bits never take part.
  function automatic logic word_match(input logic [29:0] a, input logic [29:0] b);
    return (a == b);
  endfunction

endpackage

// File: rtl/m_sync_fifo.sv
// -----------------------------------------------------------------------------
// m_sync_fifo
// Single-clock FIFO with wrap-bit pointers. The head entry is presented
// combinationally from registered state and reads as 0 while empty.
// Ports:
//   i_clk, i_reset   clock, asynchronous active-high reset (pointers only)
//   i_push, i_data   write request and data
//   i_pop            read request; ignored while empty
//   o_data           head entry
//   o_full, o_empty  occupancy flags
//   o_count          number of stored entries (log2(DEPTH)+1 bits)
// A push while full is accepted only if a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module m_sync_fifo
  import dmem_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_push_acc;
  logic             w_pop_acc;

  assign o_empty    = (r_wptr == r_rptr);
  assign o_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_count    = r_wptr - r_rptr;
  assign w_pop_acc  = i_pop && !o_empty;
  // When full, the slot being written is the one being popped this cycle.
  assign w_push_acc = i_push && (!o_full || w_pop_acc);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_acc) r_wptr <= r_wptr + 1'b1;
      if (w_pop_acc)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_acc) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

  assign o_data = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/m_dmem_responder.sv
// -----------------------------------------------------------------------------
// m_dmem_responder
// Responder on the processor data-memory bus: word RAM, a console TX FIFO
// drained through a valid/ready port, a STATUS register and an optional
// cycle counter. Reads are combinational; writes commit on the rising edge.
// Build option: define DMEM_CYCLE_COUNTER_EN to include the 32-bit cycle
// counter at CYCLE_ADDR; otherwise CYCLE reads 0 and writes are ignored.
// Ports:
//   i_clk, i_reset      clock, asynchronous active-high reset
//   i_we                write enable
//   i_address           byte address, low two bits ignored
//   i_wdata             write data
//   o_rdata             read data for i_address
//   o_tx_valid          console FIFO holds a byte
//   o_tx_data           console FIFO head byte
//   i_tx_ready          sink takes the head when o_tx_valid is high
// -----------------------------------------------------------------------------
module m_dmem_responder
  import dmem_pkg::*;
#(
  parameter int RAM_WORDS  = 256,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_we,
  input  logic [31:0] i_address,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_ready
);

  localparam int          RAM_AW    = $clog2(RAM_WORDS);
  localparam int          FIFO_AW   = $clog2(FIFO_DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  logic [31:0]       r_ram [RAM_WORDS];
  logic              r_ovf;

  logic [31:0]       w_ram_off;
  logic [RAM_AW-1:0] w_ram_idx;
  logic              w_sel_ram;
  logic              w_sel_tx;
  logic              w_sel_status;
  logic              w_sel_cycle;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [FIFO_AW:0]  w_count;
  logic [31:0]       w_status;
  logic [31:0]       w_cycle;
  logic [31:0]       w_rdata;

  // Offset compare covers the full address, so words past the RAM never alias.
  assign w_ram_off    = i_address - RAM_BASE;
  assign w_ram_idx    = w_ram_off[RAM_AW+1:2];
  assign w_sel_ram    = (w_ram_off < RAM_BYTES);
  assign w_sel_tx     = word_match(i_address[31:2], TX_DATA_ADDR[31:2]);
  assign w_sel_status = word_match(i_address[31:2], STATUS_ADDR[31:2]);
  assign w_sel_cycle  = word_match(i_address[31:2], CYCLE_ADDR[31:2]);

  assign w_push     = i_we && w_sel_tx;
  assign w_pop      = o_tx_valid && i_tx_ready;
  assign o_tx_valid = !w_empty;

  m_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_data  (i_wdata[7:0]),
    .i_pop   (w_pop),
    .o_data  (o_tx_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge i_clk) begin
    if (i_we && w_sel_ram) r_ram[w_ram_idx] <= i_wdata;
  end

  // A fresh drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ovf <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_ovf <= 1'b1;
    end else if (i_we && w_sel_status) begin
      r_ovf <= 1'b0;
    end
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] r_cycle;

  // A load shows the written value for one cycle before counting resumes.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cycle <= '0;
    end else if (i_we && w_sel_cycle) begin
      r_cycle <= i_wdata;
    end else begin
      r_cycle <= r_cycle + 32'd1;
    end
  end

  assign w_cycle = r_cycle;
`else
  assign w_cycle = '0;
`endif

  always_comb begin
    w_status                 = '0;
    w_status[STAT_COUNT_LSB +: 8] = 8'(w_count);
    w_status[STAT_OVF_BIT]   = r_ovf;
    w_status[STAT_FULL_BIT]  = w_full;
    w_status[STAT_EMPTY_BIT] = w_empty;
  end

  // TX_DATA and unmapped words fall through to 0.
  always_comb begin
    w_rdata = '0;
    if (w_sel_ram) begin
      w_rdata = r_ram[w_ram_idx];
    end else if (w_sel_status) begin
      w_rdata = w_status;
    end else if (w_sel_cycle) begin
      w_rdata = w_cycle;
    end
  end

  assign o_rdata = w_rdata;

endmodule

// File: tb/tb_m_dmem_responder.sv
module tb_m_dmem_responder;

  localparam int RAM_WORDS  = 256;
  localparam int FIFO_DEPTH = 8;
  localparam logic [31:0] A_TX  = 32'hFFFF_0000;
  localparam logic [31:0] A_ST  = 32'hFFFF_0004;
  localparam logic [31:0] A_CYC = 32'hFFFF_0008;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  m_dmem_responder #(.RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_we       (we),
    .i_address  (addr),
    .i_wdata    (wdata),
    .o_rdata    (rdata),
    .o_tx_valid (tx_valid),
    .o_tx_data  (tx_data),
    .i_tx_ready (ready)
  );

  // ---------------- behavioural model ----------------
  byte unsigned mq[$];
  bit           m_ovf;
  logic [31:0]  m_cyc;
  logic [31:0]  m_ram [int];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_cyc = 32'h0;
    end else begin : upd
      int sz;
      bit pop;
      bit push;
      sz   = mq.size();
      pop  = (sz > 0) && ready;
      push = we && (addr[31:2] == A_TX[31:2]);
      if (we && (addr < RAM_WORDS * 4)) m_ram[int'(addr[31:2])] = wdata;
      if (we && (addr[31:2] == A_ST[31:2])) m_ovf = 1'b0;
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (sz == FIFO_DEPTH && !pop) m_ovf = 1'b1;
        else mq.push_back(wdata[7:0]);
      end
`ifdef DMEM_CYCLE_COUNTER_EN
      if (we && (addr[31:2] == A_CYC[31:2])) m_cyc = wdata;
      else m_cyc = m_cyc + 32'd1;
`endif
    end
  end

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] r;
    int sz;
    r  = 32'h0;
    sz = mq.size();
    if (a < RAM_WORDS * 4) begin
      if (m_ram.exists(int'(a[31:2]))) r = m_ram[int'(a[31:2])];
      else r = 'x;
    end else if (a[31:2] == A_ST[31:2]) begin
      r[15:8] = 8'(sz);
      r[3]    = m_ovf;
      r[2]    = (sz == FIFO_DEPTH);
      r[1]    = (sz == 0);
    end else if (a[31:2] == A_CYC[31:2]) begin
`ifdef DMEM_CYCLE_COUNTER_EN
      r = m_cyc;
`endif
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle check of the drain port against the model queue.
  always @(negedge clk) begin
    check("tx_valid_model", {31'b0, tx_valid}, {31'b0, (mq.size() > 0)});
    check("tx_data_model", {24'b0, tx_data}, (mq.size() > 0) ? {24'b0, mq[0]} : 32'h0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1 we = 1'b0;
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] lit, input bit has_lit);
    @(negedge clk);
    we = 1'b0; addr = a;
    #1;
    check({name, "_model"}, rdata, model_read(a));
    if (has_lit) check(name, rdata, lit);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    byte unsigned got[$];
    byte unsigned exp_drain[$];
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    #1;
    check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    check("rst_tx_data", {24'b0, tx_data}, 32'h0);
    rd("rst_status", A_ST, 32'h0000_0002, 1'b1);

    // RAM and decode
    wr(32'h10, 32'hDEAD_BEEF);
    rd("ram_0x10", 32'h10, 32'hDEAD_BEEF, 1'b1);
    rd("ram_0x13", 32'h13, 32'hDEAD_BEEF, 1'b1);
    wr(32'h0, 32'hA5A5_A5A5);
    wr(32'h3FC, 32'h1357_9BDF);
    wr(32'h400, 32'h1234_5678);
    rd("ram_word0", 32'h0, 32'hA5A5_A5A5, 1'b1);
    rd("ram_top", 32'h3FF, 32'h1357_9BDF, 1'b1);
    rd("past_ram", 32'h400, 32'h0, 1'b1);
    rd("unmapped", 32'hFFFF_000C, 32'h0, 1'b1);
    rd("tx_read", A_TX, 32'h0, 1'b1);

    // Fill, overflow, clear
    ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(A_TX, 32'h41 + i);
    rd("status_full", A_ST, 32'h0000_0804, 1'b1);
    wr(A_TX, 32'h49);
    rd("status_ovf", A_ST, 32'h0000_080C, 1'b1);
    wr(A_ST, 32'h0);
    rd("status_ovf_clr", A_ST, 32'h0000_0804, 1'b1);

    // Simultaneous push and pop while full
    @(negedge clk);
    check("head_0x41", {24'b0, tx_data}, 32'h41);
    ready = 1'b1; we = 1'b1; addr = A_TX; wdata = 32'h50;
    @(posedge clk);
    #1 we = 1'b0; ready = 1'b0;
    check("head_0x42", {24'b0, tx_data}, 32'h42);
    rd("status_pp_full", A_ST, 32'h0000_0804, 1'b1);

    // Drain
    exp_drain = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h50};
    @(negedge clk);
    ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (!tx_valid) break;
      got.push_back(tx_data);
      @(negedge clk);
    end
    ready = 1'b0;
    check("drain_len", got.size(), exp_drain.size());
    for (int i = 0; i < exp_drain.size(); i++) begin
      if (i < got.size()) check($sformatf("drain_%0d", i), {24'b0, got[i]}, {24'b0, exp_drain[i]});
    end
    check("drain_empty", {31'b0, tx_valid}, 32'h0);

    // Push into empty FIFO, latency 1
    @(negedge clk);
    we = 1'b1; addr = A_TX; wdata = 32'h55;
    #1 check("push_lat_before", {31'b0, tx_valid}, 32'h0);
    @(posedge clk);
    #1 we = 1'b0;
    check("push_lat_valid", {31'b0, tx_valid}, 32'h1);
    check("push_lat_data", {24'b0, tx_data}, 32'h55);
    @(negedge clk);
    ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
    check("pop_single", {31'b0, tx_valid}, 32'h0);

    // Push with ready while empty: only the push happens
    @(negedge clk);
    ready = 1'b1; we = 1'b1; addr = A_TX; wdata = 32'h66;
    @(posedge clk);
    #1 we = 1'b0;
    check("empty_pp_valid", {31'b0, tx_valid}, 32'h1);
    check("empty_pp_data", {24'b0, tx_data}, 32'h66);
    @(posedge clk);
    #1 ready = 1'b0;
    check("empty_pp_drained", {31'b0, tx_valid}, 32'h0);

    // Cycle counter
`ifdef DMEM_CYCLE_COUNTER_EN
    rd("cycle_running", A_CYC, 32'h0, 1'b0);
    wr(A_CYC, 32'hFFFF_FFFE);
    rd("cycle_load", A_CYC, 32'hFFFF_FFFE, 1'b1);
    rd("cycle_p1", A_CYC, 32'hFFFF_FFFF, 1'b1);
    rd("cycle_wrap", A_CYC, 32'h0000_0000, 1'b1);
    rd("cycle_p3", A_CYC, 32'h0000_0001, 1'b1);
`else
    wr(A_CYC, 32'hFFFF_FFFE);
    rd("cycle_off", A_CYC, 32'h0, 1'b1);
    rd("cycle_off2", A_CYC, 32'h0, 1'b1);
`endif

    // Reset mid-drain
    for (int i = 0; i < 9; i++) wr(A_TX, 32'h70 + i);
    rd("pre_rst_status", A_ST, 32'h0000_080C, 1'b1);
    @(negedge clk);
    ready = 1'b1;
    repeat (5) @(negedge clk);
    #1 check("pre_rst_head", {24'b0, tx_data}, 32'h75);
    #1 rst = 1'b1;
    #1;
    check("rst_async_valid", {31'b0, tx_valid}, 32'h0);
    check("rst_async_data", {24'b0, tx_data}, 32'h0);
    ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rd("post_rst_status", A_ST, 32'h0000_0002, 1'b1);
    wr(A_TX, 32'h77);
    #1 check("post_rst_head", {24'b0, tx_data}, 32'h77);
    rd("post_rst_count1", A_ST, 32'h0000_0100, 1'b1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
